// File: rtl/flash_log_sequencer.sv
// Telemetry logger front end for a NOR flash interface: buffers words in a FIFO, writes them
// at an auto-incrementing address, and serves single-word readbacks with fixed wait counts.
`timescale 1ns/1ps
module flash_log_sequencer #(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [21:0] BASE_ADDR   = 22'h0,
    parameter logic [21:0] END_ADDR    = 22'h3FFFFF,
    parameter int          WR_WAIT_CYC = 24,
    parameter int          RD_WAIT_CYC = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] WR_DATA,
    input  logic        WR_VALID,
    output logic        WR_READY,
    input  logic        RD_REQ,
    input  logic [21:0] RD_ADDR,
    output logic [15:0] RD_DATA,
    output logic        RD_DONE,
    input  logic [15:0] FLASH_D_READ,
    output logic [1:0]  CMD_OUT,
    output logic [21:0] A_OUT,
    output logic [15:0] D_OUT,
    output logic [21:0] WR_PTR,
    output logic        LOG_FULL,
    output logic [15:0] DROP_CNT,
    output logic [8:0]  FIFO_LEVEL
);
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int MAX_WAIT = (WR_WAIT_CYC > RD_WAIT_CYC) ? WR_WAIT_CYC : RD_WAIT_CYC;
    localparam int CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WR_LOAD   = CW'(WR_WAIT_CYC - 1);
    localparam logic [CW-1:0] RD_LOAD   = CW'(RD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [8:0]    DEPTH_LVL = 9'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, RD_CAPTURE
    } state_t;

    logic [15:0]   mem [FIFO_DEPTH];
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [21:0]   a_q, a_d;
    logic [15:0]   d_q, d_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          rd_done_q, rd_done_d;
    logic [21:0]   wr_ptr_q, wr_ptr_d;
    logic          log_full_q, log_full_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [8:0]    level_q, level_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic          pend_q, pend_d;
    logic [21:0]   pend_addr_q, pend_addr_d;
    logic          push, pop;

    assign WR_READY   = (level_q != DEPTH_LVL);
    assign push       = WR_VALID && WR_READY;
    assign CMD_OUT    = cmd_q;
    assign A_OUT      = a_q;
    assign D_OUT      = d_q;
    assign RD_DATA    = rd_data_q;
    assign RD_DONE    = rd_done_q;
    assign WR_PTR     = wr_ptr_q;
    assign LOG_FULL   = log_full_q;
    assign DROP_CNT   = drop_cnt_q;
    assign FIFO_LEVEL = level_q;

    // Outputs are registered on entry to each state, so the command pulse and the
    // RD_DONE/RD_DATA pair are visible during the ISSUE and CAPTURE cycles themselves.
    // The issue cycle counts toward the wait, so both wait parameters must be >= 2.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = 2'd0;
        a_d         = a_q;
        d_d         = d_q;
        rd_data_d   = rd_data_q;
        rd_done_d   = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        log_full_d  = log_full_q;
        drop_cnt_d  = drop_cnt_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = RD_ISSUE;
                    cmd_d   = 2'd1;
                    a_d     = pend_addr_q;
                    cnt_d   = RD_LOAD;
                end else if (level_q != 9'd0 && !log_full_q) begin
                    state_d = WR_ISSUE;
                    cmd_d   = 2'd2;
                    a_d     = wr_ptr_q;
                    d_d     = mem[rd_idx_q];
                    pop     = 1'b1;
                    cnt_d   = WR_LOAD;
                end else if (level_q != 9'd0) begin
                    pop = 1'b1;
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end
            end
            WR_ISSUE: begin
                cnt_d   = cnt_q - CNT_ONE;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (wr_ptr_q == END_ADDR) begin
                        log_full_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 22'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RD_ISSUE: begin
                cnt_d   = cnt_q - CNT_ONE;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = RD_CAPTURE;
                    rd_data_d = FLASH_D_READ;
                    rd_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RD_CAPTURE: begin
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A request in the capture cycle must survive the clear above.
        if (RD_REQ) begin
            pend_d      = 1'b1;
            pend_addr_d = RD_ADDR;
        end
        level_d  = level_q + 9'(push) - 9'(pop);
        rd_idx_d = rd_idx_q + AW'(pop);
        wr_idx_d = wr_idx_q + AW'(push);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= 2'd0;
            a_q         <= 22'd0;
            d_q         <= 16'd0;
            rd_data_q   <= 16'd0;
            rd_done_q   <= 1'b0;
            wr_ptr_q    <= BASE_ADDR;
            log_full_q  <= 1'b0;
            drop_cnt_q  <= 16'd0;
            level_q     <= 9'd0;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= 22'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            a_q         <= a_d;
            d_q         <= d_d;
            rd_data_q   <= rd_data_d;
            rd_done_q   <= rd_done_d;
            wr_ptr_q    <= wr_ptr_d;
            log_full_q  <= log_full_d;
            drop_cnt_q  <= drop_cnt_d;
            level_q     <= level_d;
            rd_idx_q    <= rd_idx_d;
            wr_idx_q    <= wr_idx_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET && push) begin
            mem[wr_idx_q] <= WR_DATA;
        end
    end
endmodule
